// File: rtl/pet2001cass.sv
// pet2001cass -- tape-side end of the PET Cassette #1 interface.
//
// Playback turns a stream of TAP bytes into read pulses on cass_read: byte N
// is one full cycle of N*8 us (N=0 means 256*8 us), low for the first half
// and high for the second. Record measures the period between falling edges
// of cass_write and turns it back into TAP bytes. The time base is the
// shared 1 MHz slow_clock enable; both directions only advance while the
// PET has the motor running.

module pet2001cass (
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_clock,
  input  logic       cass_motor_n,
  input  logic       cass_write,
  output logic       cass_read,
  output logic       cass_sense_n,
  input  logic       play_en,
  input  logic [7:0] play_data,
  input  logic       play_valid,
  output logic       play_ready,
  output logic       play_underrun,
  input  logic       rec_en,
  output logic [7:0] rec_data,
  output logic       rec_valid,
  input  logic       rec_ready,
  output logic       rec_overrun
);

  // ---------------------------------------------------------------------------
  // Shared terms
  // ---------------------------------------------------------------------------

  // Saturation value of the 11-bit microsecond counters.
  localparam logic [10:0] CNT_MAX = 11'h7ff;

  logic motor_on;
  assign motor_on = !cass_motor_n;

  // ---------------------------------------------------------------------------
  // Playback
  // ---------------------------------------------------------------------------

  // Encoding keeps PLOW the only state with msb=1/lsb=0, and every legal
  // transition into or out of PLOW flips at most one bit except
  // PFETCH->PLOW, whose intermediate codes both decode as "high". The
  // decoded cass_read therefore never glitches low.
  localparam logic [1:0] PIDLE  = 2'b00;
  localparam logic [1:0] PFETCH = 2'b01;
  localparam logic [1:0] PLOW   = 2'b10;
  localparam logic [1:0] PHIGH  = 2'b11;

  logic [1:0]  pstate;
  logic [10:0] half;       // half-period of the current byte, in us
  logic [10:0] pcnt;       // remaining us in the current half
  logic        play_stop;  // PLAY released or RECORD pressed
  logic        ptick;      // a microsecond that actually counts for playback
  logic [10:0] play_half;  // half-period of the byte on play_data

  assign play_stop = !play_en || rec_en;
  assign ptick     = slow_clock && motor_on;

  // N*4 us, with N=0 standing for 256 so the half-period becomes 1024 us.
  assign play_half = {(play_data == 8'd0), play_data, 2'b00};

  assign play_ready = (pstate == PFETCH) && motor_on;

  // Reading straight off the state register makes an asynchronous reset
  // return the line high at once, without waiting for a clock.
  assign cass_read = (pstate != PLOW);

  // Playback FSM: fetch a byte, count out the low half, then the high half.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pstate        <= PIDLE;
      half          <= '0;
      pcnt          <= '0;
      play_underrun <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values; the later play_stop override relies on the
      // last scheduled non-blocking update winning.
      case (pstate)
        PIDLE: begin
          play_underrun <= 1'b0;
          if (!play_stop) pstate <= PFETCH;
        end
        PFETCH: begin
          if (motor_on) begin
            if (play_valid) begin
              half   <= play_half;
              pcnt   <= play_half;
              pstate <= PLOW;
            end else if (slow_clock) begin
              play_underrun <= 1'b1;
            end
          end
        end
        PLOW: begin
          if (ptick) begin
            if (pcnt == 11'd1) begin
              pcnt   <= half;
              pstate <= PHIGH;
            end else begin
              pcnt <= pcnt - 11'd1;
            end
          end
        end
        PHIGH: begin
          if (ptick) begin
            if (pcnt == 11'd1) pstate <= PFETCH;
            else               pcnt   <= pcnt - 11'd1;
          end
        end
        default: pstate <= PIDLE;
      endcase

      // Releasing PLAY or pressing RECORD aborts playback from any state.
      if (play_stop) pstate <= PIDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Key sense
  // ---------------------------------------------------------------------------

  // Registered key-sense line, low while either key is down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cass_sense_n <= 1'b1;
    else       cass_sense_n <= !(play_en || rec_en);
  end

  // ---------------------------------------------------------------------------
  // Record
  // ---------------------------------------------------------------------------

  localparam logic [1:0] RIDLE = 2'b00;
  localparam logic [1:0] RARM  = 2'b01;
  localparam logic [1:0] RMEAS = 2'b10;

  logic [1:0]  rstate;
  logic        wr_q;       // cass_write one clock ago
  logic        wr_fall;
  logic [10:0] rcnt;       // us since the last falling edge, saturating
  logic [11:0] rounded;    // rcnt + half a TAP unit, for round-to-nearest
  logic [8:0]  units;      // period in 8 us TAP units
  logic [7:0]  meas_byte;
  logic        emit;

  // cass_write comes from the VIA in this clock domain, so a single register
  // is enough to see the edge.
  assign wr_fall = wr_q && !cass_write;

  assign rounded = {1'b0, rcnt} + 12'd4;
  assign units   = rounded[11:3];

  // A period ends, and a byte is produced, on a falling edge while measuring.
  assign emit = (rstate == RMEAS) && rec_en && motor_on && wr_fall;

  // Map the measured period onto a TAP byte: too long wraps to the 256-unit
  // code 0, and anything shorter than half a unit is the shortest code 1.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches
    // whichever branch is taken.
    meas_byte = units[7:0];
    if (units[8])                meas_byte = 8'd0;
    else if (units[7:0] == 8'd0) meas_byte = 8'd1;
  end

  // Registered copy of cass_write; idles high so no edge appears out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_q <= 1'b1;
    else       wr_q <= cass_write;
  end

  // Record FSM: arm on the first edge, then time every following period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate <= RIDLE;
      rcnt   <= '0;
    end else if (!rec_en) begin
      rstate <= RIDLE;
    end else begin
      case (rstate)
        RIDLE: begin
          if (motor_on) rstate <= RARM;
        end
        RARM: begin
          if (motor_on && wr_fall) begin
            rcnt   <= '0;
            rstate <= RMEAS;
          end
        end
        RMEAS: begin
          if (!motor_on) begin
            rstate <= RARM;
          end else if (wr_fall) begin
            rcnt <= '0;
          end else if (slow_clock && (rcnt != CNT_MAX)) begin
            rcnt <= rcnt + 11'd1;
          end
        end
        default: rstate <= RIDLE;
      endcase
    end
  end

  // Output holding register: one byte deep, drops new bytes while full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_data    <= '0;
      rec_valid   <= 1'b0;
      rec_overrun <= 1'b0;
    end else begin
      if (rec_valid && rec_ready) rec_valid <= 1'b0;

      if (emit) begin
        if (rec_valid && !rec_ready) begin
          rec_overrun <= 1'b1;
        end else begin
          rec_data  <= meas_byte;
          rec_valid <= 1'b1;
        end
      end

      if (rstate == RIDLE) rec_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pet2001cass.sv
// Self-checking bench for pet2001cass: directed sequence with randomized
// TAP bytes and write periods, checked against pulse widths measured on the
// outputs and a TAP rounding model computed from the byte rules.

module tb_pet2001cass;

  logic       clk = 1'b0;
  logic       reset;
  logic       slow_clock;
  logic       cass_motor_n;
  logic       cass_write;
  logic       cass_read;
  logic       cass_sense_n;
  logic       play_en;
  logic [7:0] play_data;
  logic       play_valid;
  logic       play_ready;
  logic       play_underrun;
  logic       rec_en;
  logic [7:0] rec_data;
  logic       rec_valid;
  logic       rec_ready;
  logic       rec_overrun;

  int checks = 0;
  int errors = 0;

  localparam int WAIT_BUDGET = 12000;

  pet2001cass dut (
    .clk           (clk),
    .reset         (reset),
    .slow_clock    (slow_clock),
    .cass_motor_n  (cass_motor_n),
    .cass_write    (cass_write),
    .cass_read     (cass_read),
    .cass_sense_n  (cass_sense_n),
    .play_en       (play_en),
    .play_data     (play_data),
    .play_valid    (play_valid),
    .play_ready    (play_ready),
    .play_underrun (play_underrun),
    .rec_en        (rec_en),
    .rec_data      (rec_data),
    .rec_valid     (rec_valid),
    .rec_ready     (rec_ready),
    .rec_overrun   (rec_overrun)
  );

  always #5 clk = ~clk;

  // 1 us strobe: one clk wide, every third clk.
  initial begin
    int div;
    div = 0;
    slow_clock = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = (div == 2) ? 0 : div + 1;
      slow_clock = (div == 0);
    end
  end

  // Overall time limit.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Output monitor: pulse runs on cass_read, handshakes, recorded bytes
  // ---------------------------------------------------------------------------

  typedef struct {
    logic level;
    int   ticks;   // microseconds that elapsed with the motor on
    int   wall;    // all microseconds
  } run_t;

  run_t       runs[$];
  logic [7:0] rec_seen[$];
  int         hs_count = 0;
  bit         run_open = 1'b0;
  logic       run_level;
  int         run_ticks;
  int         run_wall;

  // A tick seen at the falling edge is consumed at the next rising edge,
  // so it belongs to the run currently visible on cass_read.
  always @(negedge clk) begin
    run_t r;
    if (play_ready && play_valid) hs_count++;
    if (rec_valid && rec_ready) rec_seen.push_back(rec_data);
    if (reset || play_ready) begin
      if (run_open) begin
        r.level = run_level; r.ticks = run_ticks; r.wall = run_wall;
        runs.push_back(r);
      end
      run_open = 1'b0;
    end else begin
      if (run_open && (cass_read !== run_level)) begin
        r.level = run_level; r.ticks = run_ticks; r.wall = run_wall;
        runs.push_back(r);
        run_open = 1'b0;
      end
      if (!run_open) begin
        run_open  = 1'b1;
        run_level = cass_read;
        run_ticks = 0;
        run_wall  = 0;
      end
      if (slow_clock) begin
        run_wall++;
        if (!cass_motor_n) run_ticks++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and helpers
  // ---------------------------------------------------------------------------

  // Microseconds of one half-period for TAP byte n.
  function automatic int half_us(input logic [7:0] n);
    return ((n == 8'd0) ? 256 : int'(n)) * 4;
  endfunction

  // TAP byte for a measured period: nearest multiple of 8 us, the counter
  // capped at 2047 us, 256 units coded as 0 and 0 units raised to 1.
  function automatic logic [7:0] tap_byte(input int us);
    int sat;
    int units;
    logic [7:0] b;
    sat   = (us > 2047) ? 2047 : us;
    units = (sat + 4) / 8;
    if (units > 255)      b = 8'd0;
    else if (units == 0)  b = 8'd1;
    else                  b = units[7:0];
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the rising edge that consumed the n-th strobe.
  task automatic tick_wait(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(negedge clk);
      if (slow_clock) c++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_handshake(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < WAIT_BUDGET && !seen; i++) begin
      @(negedge clk);
      if (play_ready && play_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL %s: observed no handshake expected play_ready", tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < WAIT_BUDGET && !seen; i++) begin
      @(negedge clk);
      if (play_ready) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL %s: observed play_ready=0 expected 1", tag);
    end
    @(posedge clk);
    #1;
  endtask

  // One write period: falling edge now, high again half-way through.
  task automatic wr_period(input int p);
    cass_write = 1'b0;
    tick_wait(p / 2);
    cass_write = 1'b1;
    tick_wait(p - p / 2);
  endtask

  task automatic wr_final_edge();
    cass_write = 1'b0;
    cyc(3);
    cass_write = 1'b1;
    cyc(3);
  endtask

  logic [7:0] stream[$];

  // Plays every byte of stream back to back and checks each pulse width.
  task automatic play_stream(input string tag);
    int n;
    n = stream.size();
    hs_count = 0;
    play_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      play_data  = stream[i];
      play_valid = 1'b1;
      wait_handshake(tag);
      if (i == 0) runs.delete();
    end
    play_valid = 1'b0;
    wait_ready(tag);
    check({tag, "_handshakes"}, hs_count, n);
    check({tag, "_runs"}, runs.size(), 2 * n);
    for (int i = 0; i < n && 2 * i + 1 < runs.size(); i++) begin
      check($sformatf("%s_low%0d_level", tag, i), runs[2 * i].level, 1'b0);
      check($sformatf("%s_low%0d_us", tag, i), runs[2 * i].ticks, half_us(stream[i]));
      check($sformatf("%s_high%0d_level", tag, i), runs[2 * i + 1].level, 1'b1);
      check($sformatf("%s_high%0d_us", tag, i), runs[2 * i + 1].ticks, half_us(stream[i]));
    end
  endtask

  // Starved fetch: underrun sets, line stays high, releasing PLAY clears it.
  task automatic end_stream(input string tag);
    tick_wait(2);
    check({tag, "_underrun"}, play_underrun, 1'b1);
    check({tag, "_read_high"}, cass_read, 1'b1);
    play_en = 1'b0;
    cyc(3);
    check({tag, "_underrun_clear"}, play_underrun, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------

  initial begin
    int periods[$];
    int pa;
    int pb;

    reset        = 1'b1;
    play_en      = 1'b1;
    rec_en       = 1'b0;
    cass_motor_n = 1'b0;
    cass_write   = 1'b1;
    play_valid   = 1'b0;
    play_data    = 8'h00;
    rec_ready    = 1'b1;

    // Reset with PLAY held down.
    cyc(3);
    check("rst_cass_read", cass_read, 1'b1);
    check("rst_sense_n", cass_sense_n, 1'b1);
    check("rst_play_ready", play_ready, 1'b0);
    check("rst_underrun", play_underrun, 1'b0);
    check("rst_rec_data", rec_data, 8'h00);
    check("rst_rec_valid", rec_valid, 1'b0);
    check("rst_overrun", rec_overrun, 1'b0);
    reset = 1'b0;
    cyc(1);
    check("sense_after_reset", cass_sense_n, 1'b0);
    end_stream("startup");
    check("sense_released", cass_sense_n, 1'b1);

    // Two fixed bytes.
    stream = '{8'h30, 8'h42};
    play_stream("pb_30_42");
    end_stream("pb_30_42");

    // Longest byte.
    stream = '{8'h00};
    play_stream("pb_00");
    end_stream("pb_00");

    // Random bytes back to back.
    stream.delete();
    for (int i = 0; i < 4; i++) stream.push_back(8'($urandom_range(1, 60)));
    play_stream("pb_rand");
    end_stream("pb_rand");

    // Motor stopped for 100 us in the middle of the low half of byte 0x00.
    play_en    = 1'b1;
    play_data  = 8'h00;
    play_valid = 1'b1;
    wait_handshake("motor");
    runs.delete();
    play_valid = 1'b0;
    tick_wait(300);
    cass_motor_n = 1'b1;
    tick_wait(50);
    check("motor_off_read_low", cass_read, 1'b0);
    check("motor_off_ready", play_ready, 1'b0);
    tick_wait(50);
    cass_motor_n = 1'b0;
    wait_ready("motor");
    check("motor_runs", runs.size(), 2);
    if (runs.size() >= 2) begin
      check("motor_low_wall_us", runs[0].wall, 1124);
      check("motor_low_run_us", runs[0].ticks, 1024);
      check("motor_high_us", runs[1].ticks, 1024);
    end
    end_stream("motor");

    // Asynchronous reset in the middle of a low half.
    play_en    = 1'b1;
    play_data  = 8'h10;
    play_valid = 1'b1;
    wait_handshake("async");
    play_valid = 1'b0;
    tick_wait(10);
    check("async_before_low", cass_read, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_read_high", cass_read, 1'b1);
    play_en = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(2);

    // RECORD wins over PLAY.
    play_en = 1'b1;
    rec_en  = 1'b1;
    cyc(4);
    check("prio_play_ready", play_ready, 1'b0);
    check("prio_read_high", cass_read, 1'b1);
    play_en = 1'b0;
    rec_en  = 1'b0;
    cyc(3);

    // Record: fixed and random periods, consumer always ready.
    rec_en    = 1'b1;
    rec_ready = 1'b1;
    cyc(3);
    rec_seen.delete();
    periods = '{352, 352, 352, 2100, 2};
    for (int i = 0; i < 3; i++) periods.push_back($urandom_range(3, 700));
    foreach (periods[i]) begin
      wr_period(periods[i]);
      if (i == 0) check("rec_arm_no_byte", rec_seen.size(), 0);
    end
    wr_final_edge();
    check("rec_count", rec_seen.size(), periods.size());
    for (int i = 0; i < periods.size() && i < rec_seen.size(); i++)
      check($sformatf("rec_byte%0d_p%0d", i, periods[i]), rec_seen[i], tap_byte(periods[i]));
    check("rec_no_overrun", rec_overrun, 1'b0);

    // Record with the consumer stalled: second byte dropped.
    rec_en = 1'b0;
    cyc(3);
    rec_en    = 1'b1;
    rec_ready = 1'b0;
    cyc(3);
    rec_seen.delete();
    pa = $urandom_range(40, 400);
    pb = $urandom_range(500, 1000);
    wr_period(pa);
    wr_period(pb);
    wr_final_edge();
    check("ovr_valid", rec_valid, 1'b1);
    check("ovr_data", rec_data, tap_byte(pa));
    check("ovr_flag", rec_overrun, 1'b1);
    rec_ready = 1'b1;
    cyc(1);
    rec_ready = 1'b0;
    check("ovr_drained_valid", rec_valid, 1'b0);
    check("ovr_drained_count", rec_seen.size(), 1);
    if (rec_seen.size() >= 1) check("ovr_drained_byte", rec_seen[0], tap_byte(pa));
    check("ovr_sticky", rec_overrun, 1'b1);
    rec_en = 1'b0;
    cyc(3);
    check("ovr_cleared", rec_overrun, 1'b0);
    check("final_sense_n", cass_sense_n, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
